// File: rtl/calc_pkg.sv
// Shared definitions for the postfix evaluator: token tags, opcodes, error codes, FSM states.
package calc_pkg;

    localparam logic [1:0] TAG_CONST = 2'b00;
    localparam logic [1:0] TAG_OP    = 2'b01;

    localparam logic [7:0] OP_ADD  = 8'h2A;
    localparam logic [7:0] OP_SUB  = 8'h2B;
    localparam logic [7:0] OP_MUL  = 8'h2C;
    localparam logic [7:0] OP_DIV  = 8'h2D;
    localparam logic [7:0] OP_POW  = 8'hF2;
    localparam logic [7:0] OP_ROOT = 8'hF3;

    localparam logic [7:0] OP_EXP  = 8'hF0;
    localparam logic [7:0] OP_LN   = 8'hF1;
    localparam logic [7:0] OP_SQRT = 8'hF4;
    localparam logic [7:0] OP_SIN  = 8'hF5;
    localparam logic [7:0] OP_COS  = 8'hF6;

    typedef enum logic [2:0] {
        ERR_OK        = 3'd0,
        ERR_UNDERFLOW = 3'd1,
        ERR_OVERFLOW  = 3'd2,
        ERR_BADOP     = 3'd3,
        ERR_LEFTOVER  = 3'd4,
        ERR_TIMEOUT   = 3'd5
    } err_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_FINISH,
        S_DRAIN
    } state_t;

    function automatic logic isBinary(input logic [7:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) ||
               (op == OP_DIV) || (op == OP_POW) || (op == OP_ROOT);
    endfunction

    function automatic logic isUnary(input logic [7:0] op);
        return (op == OP_EXP) || (op == OP_LN) || (op == OP_SQRT) ||
               (op == OP_SIN) || (op == OP_COS);
    endfunction

endpackage

// File: rtl/eval_stack.sv
// Operand LIFO: one push or pop per cycle, top two entries always readable.
// Bounds flags are combinational so the caller can check before touching sp.
module eval_stack #(
    parameter  int DEPTH = 16,
    parameter  int VW    = 42,
    localparam int SPW   = $clog2(DEPTH + 1)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           clear,
    input  logic           push,
    input  logic [VW-1:0]  push_data,
    input  logic           pop1,
    input  logic           pop2,
    output logic [VW-1:0]  top0,
    output logic [VW-1:0]  top1,
    output logic [SPW-1:0] sp,
    output logic           full,
    output logic           under1,
    output logic           under2
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [VW-1:0]  stk_q [DEPTH];
    logic [SPW-1:0] sp_q, sp_d;
    logic [AW-1:0]  wr_idx, idx0, idx1;

    assign wr_idx = AW'(sp_q);
    assign idx0   = AW'(sp_q - SPW'(1));
    assign idx1   = AW'(sp_q - SPW'(2));

    assign full   = (sp_q == SPW'(DEPTH));
    assign under1 = (sp_q == '0);
    assign under2 = (sp_q < SPW'(2));

    assign top0 = stk_q[idx0];
    assign top1 = stk_q[idx1];
    assign sp   = sp_q;

    always_comb begin
        sp_d = sp_q;
        if (clear)
            sp_d = '0;
        else if (push && !full)
            sp_d = sp_q + SPW'(1);
        else if (pop2 && !under2)
            sp_d = sp_q - SPW'(2);
        else if (pop1 && !under1)
            sp_d = sp_q - SPW'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            sp_q <= '0;
        else
            sp_q <= sp_d;
    end

    // Storage is deliberately left unreset; only sp defines what is live.
    always_ff @(posedge clock) begin
        if (push && !full && !clear)
            stk_q[wr_idx] <= push_data;
    end

endmodule

// File: rtl/postfix_eval_engine.sv
// Streaming postfix evaluator: stacks constants, ships operators to an external ALU via req/ack.
// Optional opAck watchdog enabled by defining POSTEVAL_TIMEOUT_EN.
module postfix_eval_engine
    import calc_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int MANT_W  = 34,
    parameter int EXP_W   = 7,
    parameter int W       = 2 + 1 + MANT_W + EXP_W,
    parameter int TMO_CYC = 1023
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      tokValid,
    output logic                      tokReady,
    input  logic [W-1:0]              tokData,
    input  logic                      tokLast,
    output logic                      opReq,
    output logic [7:0]                opCode,
    output logic [1+MANT_W+EXP_W-1:0] opA,
    output logic [1+MANT_W+EXP_W-1:0] opB,
    input  logic                      opAck,
    input  logic [1+MANT_W+EXP_W-1:0] opRes,
    output logic                      resValid,
    output logic [W-1:0]              resData,
    output logic [2:0]                resErr,
    output logic                      busy
);

    localparam int VW  = 1 + MANT_W + EXP_W;
    localparam int SPW = $clog2(DEPTH + 1);

    state_t          state_q, state_d;
    err_t            err_q, err_d, tok_err, res_err;
    logic            last_q, last_d;
    logic [7:0]      op_code_q, op_code_d;
    logic [VW-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;

    logic            st_clear, st_push, st_pop1, st_pop2;
    logic [VW-1:0]   st_push_data, top0, top1;
    logic [SPW-1:0]  sp;
    logic            stk_full, stk_under1, stk_under2;

    logic            tok_ready, tok_acc, res_valid;
    logic [W-1:0]    res_data;
    logic [1:0]      tok_tag;
    logic [7:0]      tok_op;

    assign tok_tag   = tokData[W-1:W-2];
    assign tok_op    = tokData[7:0];
    assign tok_ready = (state_q == S_READ) || (state_q == S_DRAIN);
    assign tok_acc   = tokValid && tok_ready;

    eval_stack #(
        .DEPTH(DEPTH),
        .VW   (VW)
    ) u_stack (
        .clock    (clock),
        .reset    (reset),
        .clear    (st_clear),
        .push     (st_push),
        .push_data(st_push_data),
        .pop1     (st_pop1),
        .pop2     (st_pop2),
        .top0     (top0),
        .top1     (top1),
        .sp       (sp),
        .full     (stk_full),
        .under1   (stk_under1),
        .under2   (stk_under2)
    );

`ifdef POSTEVAL_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYC + 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_expired;

    // Counts cycles spent in S_WAIT; zero on every entry.
    always_comb begin
        tmo_d = '0;
        if (state_q == S_WAIT)
            tmo_d = tmo_q + TW'(1);
    end

    assign tmo_expired = (tmo_q == TW'(TMO_CYC - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            tmo_q <= '0;
        else
            tmo_q <= tmo_d;
    end
`else
    logic tmo_unused;
    assign tmo_unused = |TMO_CYC;
`endif

    always_comb begin
        state_d      = state_q;
        err_d        = err_q;
        last_d       = last_q;
        op_code_d    = op_code_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        tok_err      = ERR_OK;
        st_clear     = 1'b0;
        st_push      = 1'b0;
        st_pop1      = 1'b0;
        st_pop2      = 1'b0;
        st_push_data = tokData[VW-1:0];
        res_valid    = 1'b0;
        res_data     = '0;
        res_err      = ERR_OK;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    st_clear = 1'b1;
                    err_d    = ERR_OK;
                    last_d   = 1'b0;
                    state_d  = S_READ;
                end
            end

            S_READ: begin
                if (tok_acc) begin
                    if (tok_tag == TAG_CONST) begin
                        if (stk_full) begin
                            tok_err = ERR_OVERFLOW;
                        end else begin
                            st_push = 1'b1;
                            if (tokLast)
                                state_d = S_FINISH;
                        end
                    end else if (tok_tag == TAG_OP && isBinary(tok_op)) begin
                        if (stk_under2) begin
                            tok_err = ERR_UNDERFLOW;
                        end else begin
                            st_pop2   = 1'b1;
                            op_a_d    = top1;
                            op_b_d    = top0;
                            op_code_d = tok_op;
                            last_d    = tokLast;
                            state_d   = S_WAIT;
                        end
                    end else if (tok_tag == TAG_OP && isUnary(tok_op)) begin
                        if (stk_under1) begin
                            tok_err = ERR_UNDERFLOW;
                        end else begin
                            st_pop1   = 1'b1;
                            op_a_d    = top0;
                            op_b_d    = '0;
                            op_code_d = tok_op;
                            last_d    = tokLast;
                            state_d   = S_WAIT;
                        end
                    end else begin
                        tok_err = ERR_BADOP;
                    end

                    if (tok_err != ERR_OK) begin
                        err_d   = tok_err;
                        state_d = tokLast ? S_FINISH : S_DRAIN;
                    end
                end
            end

            S_WAIT: begin
                if (opAck) begin
                    st_push      = 1'b1;
                    st_push_data = opRes;
                    state_d      = last_q ? S_FINISH : S_READ;
                end
`ifdef POSTEVAL_TIMEOUT_EN
                else if (tmo_expired) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = last_q ? S_FINISH : S_DRAIN;
                end
`endif
            end

            S_DRAIN: begin
                if (tok_acc && tokLast)
                    state_d = S_FINISH;
            end

            S_FINISH: begin
                res_valid = 1'b1;
                state_d   = S_IDLE;
                if (err_q != ERR_OK) begin
                    res_err = err_q;
                end else if (sp == SPW'(1)) begin
                    res_data = {TAG_CONST, top0};
                end else begin
                    res_err = ERR_LEFTOVER;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            err_q     <= ERR_OK;
            last_q    <= 1'b0;
            op_code_q <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            last_q    <= last_d;
            op_code_q <= op_code_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
        end
    end

    // opReq follows the state flop so an async reset drops it at once.
    assign opReq    = (state_q == S_WAIT);
    assign opCode   = op_code_q;
    assign opA      = op_a_q;
    assign opB      = op_b_q;
    assign tokReady = tok_ready;
    assign resValid = res_valid;
    assign resData  = res_data;
    assign resErr   = res_err;
    assign busy     = (state_q != S_IDLE);

endmodule
